sram_port0_arbiter: RTL and testbench

Sequencer and two-way round-robin arbiter for the read/write port (port 0) of the 32x256 sky130 SRAM macro in the user project area. Requester A is the management SoC Wishbone slave bus. Requester B is a generic req/gnt test-engine port driven from LA or IO logic. The block owns all port-0 control, address and data pins, and the registered read-data capture. It ties port 1 idle.

---
 rtl/sram_port0_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_arbiter.sv
`default_nettype none
// =====================================================================
// sram_port0_arbiter - SRAM port-0 sequencer with Wishbone/B round-robin
// Revision 1.0
// =====================================================================
module sram_port0_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wmask,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        sram_clk0_o,
  output logic        sram_csb0_o,
  output logic        sram_web0_o,
  output logic [3:0]  sram_wmask0_o,
  output logic [7:0]  sram_addr0_o,
  output logic [31:0] sram_din0_o,
  input  logic [31:0] sram_dout0_i,
  output logic        sram_csb1_o,
  output logic        busy_o
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     state;
  logic       owner_b;
  logic       is_write;
  logic       last_grant_b;
  logic [1:0] lat_cnt;

  logic a_valid;
  logic b_valid;
  logic grant_a;
  logic grant_b;
  logic unused_adr_lsb;

  // A write ack lands in the IDLE cycle after DONE; masking A while ack is
  // high keeps a master that still holds stb from being serviced twice.
  assign a_valid = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                   (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign b_valid = b_req;
  assign grant_a = a_valid && (!b_valid || last_grant_b);
  assign grant_b = b_valid && !grant_a;

  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  assign sram_clk0_o = wb_clk_i;
  assign sram_csb1_o = 1'b1;
  assign busy_o      = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      owner_b       <= 1'b0;
      is_write      <= 1'b0;
      last_grant_b  <= 1'b1;
      lat_cnt       <= 2'd0;
      sram_csb0_o   <= 1'b1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= 4'd0;
      sram_addr0_o  <= 8'd0;
      sram_din0_o   <= 32'd0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= 32'd0;
      b_gnt         <= 1'b0;
      b_rvalid      <= 1'b0;
      b_rdata       <= 32'd0;
    end else begin
      wbs_ack_o <= 1'b0;
      b_gnt     <= 1'b0;
      b_rvalid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            sram_csb0_o  <= 1'b0;
            owner_b      <= grant_b;
            last_grant_b <= grant_b;
            b_gnt        <= grant_b;
            if (grant_b) begin
              sram_web0_o   <= ~b_we;
              sram_wmask0_o <= b_we ? b_wmask : 4'd0;
              sram_addr0_o  <= b_addr;
              sram_din0_o   <= b_wdata;
              is_write      <= b_we;
            end else begin
              sram_web0_o   <= ~wbs_we_i;
              sram_wmask0_o <= wbs_we_i ? wbs_sel_i : 4'd0;
              sram_addr0_o  <= wbs_adr_i[9:2];
              sram_din0_o   <= wbs_dat_i;
              is_write      <= wbs_we_i;
            end
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          sram_csb0_o <= 1'b1;
          sram_web0_o <= 1'b1;
          lat_cnt     <= LAT_LOAD;
          state       <= is_write ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == 2'd1) begin
            if (owner_b) begin
              b_rdata  <= sram_dout0_i;
              b_rvalid <= 1'b1;
            end else begin
              wbs_dat_o <= sram_dout0_i;
              wbs_ack_o <= 1'b1;
            end
            lat_cnt <= 2'd0;
            state   <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          if (!owner_b && is_write) begin
            wbs_ack_o <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port0_arbiter.sv
`default_nettype none
// tb_sram_port0_arbiter: instance 0 (READ_LAT=1) carries the Wishbone and
// arbitration traffic; instances 1 and 2 (READ_LAT=2,3) serve the B latency sweep.
module tb_sram_port0_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;

  logic        b_req   [3];
  logic        b_we    [3];
  logic [7:0]  b_addr  [3];
  logic [31:0] b_wdata [3];
  logic [3:0]  b_wmask [3];

  logic        ack     [3];
  logic [31:0] wdat    [3];
  logic        b_gnt   [3];
  logic        b_rvalid[3];
  logic [31:0] b_rdata [3];
  logic        sclk    [3];
  logic        csb0    [3];
  logic        web0    [3];
  logic [3:0]  wmask0  [3];
  logic [7:0]  addr0   [3];
  logic [31:0] din0    [3];
  logic        csb1    [3];
  logic        busy    [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] dout;

    sram_port0_arbiter #(
      .BASE_ADDR(32'h3000_0000),
      .READ_LAT (gi + 1)
    ) u_dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_cyc_i    (gi == 0 ? wb_cyc : 1'b0),
      .wbs_stb_i    (gi == 0 ? wb_stb : 1'b0),
      .wbs_we_i     (gi == 0 ? wb_we  : 1'b0),
      .wbs_sel_i    (gi == 0 ? wb_sel : 4'd0),
      .wbs_adr_i    (gi == 0 ? wb_adr : 32'd0),
      .wbs_dat_i    (gi == 0 ? wb_dat : 32'd0),
      .wbs_ack_o    (ack[gi]),
      .wbs_dat_o    (wdat[gi]),
      .b_req        (b_req[gi]),
      .b_we         (b_we[gi]),
      .b_addr       (b_addr[gi]),
      .b_wdata      (b_wdata[gi]),
      .b_wmask      (b_wmask[gi]),
      .b_gnt        (b_gnt[gi]),
      .b_rvalid     (b_rvalid[gi]),
      .b_rdata      (b_rdata[gi]),
      .sram_clk0_o  (sclk[gi]),
      .sram_csb0_o  (csb0[gi]),
      .sram_web0_o  (web0[gi]),
      .sram_wmask0_o(wmask0[gi]),
      .sram_addr0_o (addr0[gi]),
      .sram_din0_o  (din0[gi]),
      .sram_dout0_i (dout),
      .sram_csb1_o  (csb1[gi]),
      .busy_o       (busy[gi])
    );

    // Macro model: command sampled on the clock edge, read data held until the next read.
    always @(posedge clk) begin
      if (!csb0[gi]) begin
        if (!web0[gi]) begin
          for (int b = 0; b < 4; b++)
            if (wmask0[gi][b]) mem[addr0[gi]][8*b +: 8] <= din0[gi][8*b +: 8];
        end else begin
          dout <= mem[addr0[gi]];
        end
      end
    end
  end

  typedef struct packed {
    logic        who_b;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic who_b, input logic chk, input logic [31:0] data);
    exp_t e;
    e.who_b = who_b;
    e.chk   = chk;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic who_b, input logic [31:0] data);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed response from %s, expected none", who_b ? "B" : "A");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_who", 32'(who_b), 32'(e.who_b));
      if (e.chk) check("sb_data", data, e.data);
    end
  endtask

  function automatic void ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Response monitor for instance 0
  logic prev_low = 1'b0;
  int   ack_cnt0 = 0;
  int   csb_low_cnt0 = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_low <= 1'b0;
    end else begin
      if (ack[0]) begin
        sb_pop(1'b0, wdat[0]);
        ack_cnt0 <= ack_cnt0 + 1;
      end
      if (b_rvalid[0]) sb_pop(1'b1, b_rdata[0]);
      if (!csb0[0]) begin
        check("csb0_back_to_back", 32'(prev_low), 32'd0);
        csb_low_cnt0 <= csb_low_cnt0 + 1;
      end
      prev_low <= !csb0[0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
  endtask

  task automatic wb_stop();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit got;
    got = 0;
    if (we) begin
      ref_write(adr[9:2], dat, sel);
      sb_push(1'b0, 1'b0, 32'd0);
    end else begin
      sb_push(1'b0, 1'b1, ref_mem[adr[9:2]]);
    end
    wb_start(we, adr, dat, sel);
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (ack[0]) got = 1;
    end
    check("wb_ack_timeout", 32'(got), 32'd1);
    wb_stop();
    step();
  endtask

  task automatic b_op(input int i, input logic we, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int lat, output logic [31:0] rd);
    int g_at;
    bit got;
    lat = -1; rd = 32'd0; g_at = 0; got = 0;
    if (i == 0) begin
      if (we) ref_write(a, d, m);
      else    sb_push(1'b1, 1'b1, ref_mem[a]);
    end
    b_req[i] = 1'b1; b_we[i] = we; b_addr[i] = a; b_wdata[i] = d; b_wmask[i] = m;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (b_gnt[i]) begin
        got = 1;
        g_at = cyc_no;
      end
    end
    b_req[i] = 1'b0;
    check($sformatf("b%0d_gnt_timeout", i), 32'(got), 32'd1);
    if (!we && got) begin
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        step();
        if (b_rvalid[i]) begin
          got = 1;
          lat = cyc_no - g_at;
          rd = b_rdata[i];
        end
      end
      check($sformatf("b%0d_rvalid_timeout", i), 32'(got), 32'd1);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    int          ng;
    logic [1:0]  order [4];
    bit          a_on, b_on, got;
    int          a0, c0;

    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat = 0;
    for (int i = 0; i < 3; i++) begin
      b_req[i] = 0; b_we[i] = 0; b_addr[i] = 0; b_wdata[i] = 0; b_wmask[i] = 0;
    end
    rst = 1'b1;
    step(); step(); step();

    // Reset state
    check("rst_csb0",   32'(csb0[0]),   32'd1);
    check("rst_web0",   32'(web0[0]),   32'd1);
    check("rst_wmask0", 32'(wmask0[0]), 32'd0);
    check("rst_addr0",  32'(addr0[0]),  32'd0);
    check("rst_din0",   din0[0],        32'd0);
    check("rst_ack",    32'(ack[0]),    32'd0);
    check("rst_wdat",   wdat[0],        32'd0);
    check("rst_bgnt",   32'(b_gnt[0]),  32'd0);
    check("rst_rvalid", 32'(b_rvalid[0]), 32'd0);
    check("rst_brdata", b_rdata[0],     32'd0);
    check("rst_busy",   32'(busy[0]),   32'd0);
    check("csb1_tied",  32'(csb1[0]),   32'd1);
    rst = 1'b0;
    step();

    // Wishbone write with cycle-exact timing; stb held through the ack cycle
    ref_write(8'h04, 32'hDEADBEEF, 4'hF);
    sb_push(1'b0, 1'b0, 32'd0);
    wb_start(1'b1, 32'h3000_0010, 32'hDEADBEEF, 4'hF);
    step();
    check("wr_csb_k",   32'(csb0[0]),   32'd0);
    check("wr_addr",    32'(addr0[0]),  32'h04);
    check("wr_web",     32'(web0[0]),   32'd0);
    check("wr_wmask",   32'(wmask0[0]), 32'hF);
    check("wr_din",     din0[0],        32'hDEADBEEF);
    check("wr_busy",    32'(busy[0]),   32'd1);
    step();
    check("wr_csb_k1",  32'(csb0[0]),   32'd1);
    check("wr_ack_k1",  32'(ack[0]),    32'd0);
    step();
    check("wr_ack_k2",  32'(ack[0]),    32'd1);
    step();
    check("wr_ack_k3",  32'(ack[0]),    32'd0);
    check("wr_no_rerun", 32'(busy[0]),  32'd0);
    wb_stop();
    step();
    check("wr_csb_idle", 32'(csb0[0]),  32'd1);

    // Wishbone read-back with cycle-exact timing
    sb_push(1'b0, 1'b1, ref_mem[8'h04]);
    wb_start(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    step();
    check("rd_csb_k",   32'(csb0[0]),   32'd0);
    check("rd_web",     32'(web0[0]),   32'd1);
    check("rd_wmask",   32'(wmask0[0]), 32'd0);
    step();
    check("rd_ack_k1",  32'(ack[0]),    32'd0);
    step();
    check("rd_ack_k2",  32'(ack[0]),    32'd1);
    check("rd_data",    wdat[0],        32'hDEADBEEF);
    step();
    check("rd_ack_k3",  32'(ack[0]),    32'd0);
    wb_stop();
    step();
    check("rd_csb_idle", 32'(csb0[0]),  32'd1);

    // Byte mask
    wb_xfer(1'b1, 32'h3000_0020, 32'h11223344, 4'hF);
    wb_xfer(1'b1, 32'h3000_0020, 32'hAABBCCDD, 4'b0101);
    wb_xfer(1'b0, 32'h3000_0020, 32'd0, 4'h0);
    check("mask_readback", wdat[0], 32'h11BB33DD);

    // Non-decoding Wishbone address alongside a B read
    a0 = ack_cnt0;
    wb_start(1'b0, 32'h3100_0000, 32'd0, 4'hF);
    b_op(0, 1'b0, 8'h04, 32'd0, 4'h0, lat, rd);
    check("dec_b_data", rd, 32'hDEADBEEF);
    check("dec_b_lat",  32'(lat), 32'd2);
    c0 = csb_low_cnt0;
    repeat (8) step();
    check("dec_no_ack",   32'(ack_cnt0 - a0),     32'd0);
    check("dec_csb_idle", 32'(csb_low_cnt0 - c0), 32'd0);
    wb_stop();
    step();

    // B read latency sweep at address 8'hFF
    for (int i = 0; i < 3; i++) begin
      b_op(i, 1'b1, 8'hFF, 32'hC0DE_0000 + 32'(i), 4'hF, lat, rd);
      b_op(i, 1'b0, 8'hFF, 32'd0, 4'h0, lat, rd);
      check($sformatf("sweep_lat%0d", i + 1),  32'(lat), 32'(i + 2));
      check($sformatf("sweep_data%0d", i + 1), rd, 32'hC0DE_0000 + 32'(i));
    end

    // Reset during a Wishbone read in WAIT
    wb_start(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    step();
    check("rstA_csb_k", 32'(csb0[0]), 32'd0);
    step();
    rst = 1'b1;
    wb_stop();
    step();
    check("rstA_ack",  32'(ack[0]),  32'd0);
    check("rstA_csb",  32'(csb0[0]), 32'd1);
    check("rstA_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;

    // Contention right after reset: A first, then alternating
    ng = 0; a_on = 1; b_on = 1;
    for (int k = 0; k < 4; k++) order[k] = 2'd2;
    wb_start(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h08; b_wdata[0] = 32'd0; b_wmask[0] = 4'h0;
    for (int n = 0; n < 60 && (a_on || b_on); n++) begin
      step();
      if (!csb0[0] && ng < 4) begin
        order[ng] = {1'b0, b_gnt[0]};
        if (b_gnt[0]) sb_push(1'b1, 1'b1, ref_mem[8'h08]);
        else          sb_push(1'b0, 1'b1, ref_mem[8'h04]);
        ng++;
      end
      if (ack[0] && ng >= 3) begin
        wb_stop();
        a_on = 0;
      end
      if (b_gnt[0] && ng >= 4) begin
        b_req[0] = 1'b0;
        b_on = 0;
      end
    end
    wb_stop();
    b_req[0] = 1'b0;
    repeat (6) step();
    check("arb_grants", 32'(ng), 32'd4);
    check("arb_first_A",  32'(order[0]), 32'd0);
    check("arb_second_B", 32'(order[1]), 32'd1);
    check("arb_third_A",  32'(order[2]), 32'd0);
    check("arb_fourth_B", 32'(order[3]), 32'd1);

    // Reset during a B read in WAIT
    got = 0;
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h04;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (b_gnt[0]) got = 1;
    end
    b_req[0] = 1'b0;
    check("rstB_gnt", 32'(got), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("rstB_rvalid", 32'(b_rvalid[0]), 32'd0);
    check("rstB_csb",    32'(csb0[0]),     32'd1);
    check("rstB_busy",   32'(busy[0]),     32'd0);
    rst = 1'b0;
    step();

    // Normal accesses after the aborted ones
    wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF);
    check("post_rst_wb", wdat[0], 32'hDEADBEEF);
    b_op(0, 1'b0, 8'h08, 32'd0, 4'h0, lat, rd);
    check("post_rst_b", rd, 32'h11BB33DD);

    repeat (4) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
